// File: rtl/tile_mem_arbiter_pkg.sv
// Shared types and defaults for the two-requester tile memory arbiter.
// Holds the FSM state encoding and the default geometry.
package tile_mem_arbiter_pkg;

  typedef enum logic {
    IDLE,
    CLEAR
  } state_t;

  localparam int DEF_DW   = 8;
  localparam int DEF_ROWS = 16;
  localparam int DEF_COLS = 16;
  localparam int N_REQ    = 2;

endpackage

// File: rtl/tile_mem_arbiter_if.sv
// Requester-side bus of the tile memory arbiter.
// Two requesters, each with address, data, grant and read return.
interface tile_mem_arbiter_if
  import tile_mem_arbiter_pkg::*;
#(
  parameter int DW   = DEF_DW,
  parameter int ROWS = DEF_ROWS,
  parameter int COLS = DEF_COLS
);

  localparam int RW = $clog2(ROWS);
  localparam int CW = $clog2(COLS);

  logic          req0;
  logic          we0;
  logic [RW-1:0] row0;
  logic [CW-1:0] col0;
  logic [DW-1:0] wdata0;
  logic          gnt0;
  logic          rvalid0;
  logic [DW-1:0] rdata0;

  logic          req1;
  logic          we1;
  logic [RW-1:0] row1;
  logic [CW-1:0] col1;
  logic [DW-1:0] wdata1;
  logic          gnt1;
  logic          rvalid1;
  logic [DW-1:0] rdata1;

  modport master (
    output req0, we0, row0, col0, wdata0,
    output req1, we1, row1, col1, wdata1,
    input  gnt0, rvalid0, rdata0,
    input  gnt1, rvalid1, rdata1
  );

  modport slave (
    input  req0, we0, row0, col0, wdata0,
    input  req1, we1, row1, col1, wdata1,
    output gnt0, rvalid0, rdata0,
    output gnt1, rvalid1, rdata1
  );

endinterface

// File: rtl/tile_mem_sp.sv
// Single-port tile storage: synchronous write, registered read.
// Contents are never reset; only writes or a clear sweep define them.
module tile_mem_sp #(
  parameter int DW    = 8,
  parameter int DEPTH = 256
) (
  input  logic                     clk,
  input  logic                     en,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] addr,
  input  logic [DW-1:0]            wdata,
  output logic [DW-1:0]            rdata
);

  logic [DW-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (en) begin
      if (we) mem[addr] <= wdata;
      else    rdata     <= mem[addr];
    end
  end

endmodule

// File: rtl/tile_mem_arbiter.sv
// Round-robin arbiter for two requesters over one tile memory,
// with a full-memory clear sweep and a contention counter.
module tile_mem_arbiter
  import tile_mem_arbiter_pkg::*;
#(
  parameter int DW   = DEF_DW,
  parameter int ROWS = DEF_ROWS,
  parameter int COLS = DEF_COLS
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clr_start,
  output logic        clr_busy,
  output logic [15:0] coll_cnt,
  tile_mem_arbiter_if.slave bus
);

  localparam int RW    = $clog2(ROWS);
  localparam int CW    = $clog2(COLS);
  localparam int AW    = RW + CW;
  localparam int DEPTH = ROWS * COLS;
  localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

  state_t             state;
  logic [AW-1:0]      clr_addr;
  logic               last_gnt;
  logic [15:0]        coll_q;
  logic [N_REQ-1:0]   rvalid_q;
  logic [DW-1:0]      hold0;
  logic [DW-1:0]      hold1;

  logic               idle;
  logic               can;
  logic               g0;
  logic               g1;

  logic               m_en;
  logic               m_we;
  logic [AW-1:0]      m_addr;
  logic [DW-1:0]      m_wdata;
  logic [DW-1:0]      m_rdata;

  // clr_start steals its own cycle from any pending request
  always_comb begin
    idle = (state == IDLE);
    can  = idle & ~clr_start;
    g0   = can & bus.req0 & (~bus.req1 | last_gnt);
    g1   = can & bus.req1 & (~bus.req0 | ~last_gnt);
  end

  assign bus.gnt0 = g0;
  assign bus.gnt1 = g1;

  always_comb begin
    m_en    = 1'b0;
    m_we    = 1'b0;
    m_addr  = '0;
    m_wdata = '0;
    unique case (1'b1)
      (state == CLEAR): begin
        m_en   = 1'b1;
        m_we   = 1'b1;
        m_addr = clr_addr;
      end
      g0: begin
        m_en    = 1'b1;
        m_we    = bus.we0;
        m_addr  = {bus.row0, bus.col0};
        m_wdata = bus.wdata0;
      end
      g1: begin
        m_en    = 1'b1;
        m_we    = bus.we1;
        m_addr  = {bus.row1, bus.col1};
        m_wdata = bus.wdata1;
      end
      default: ;
    endcase
  end

  tile_mem_sp #(
    .DW    (DW),
    .DEPTH (DEPTH)
  ) u_mem (
    .clk   (clk),
    .en    (m_en),
    .we    (m_we),
    .addr  (m_addr),
    .wdata (m_wdata),
    .rdata (m_rdata)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      clr_busy <= 1'b0;
      clr_addr <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (clr_start) begin
            state    <= CLEAR;
            clr_busy <= 1'b1;
            clr_addr <= '0;
          end
        end
        CLEAR: begin
          if (clr_addr == LAST) begin
            state    <= IDLE;
            clr_busy <= 1'b0;
          end else begin
            clr_addr <= clr_addr + AW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_gnt <= 1'b1;
      coll_q   <= '0;
      rvalid_q <= '0;
      hold0    <= '0;
      hold1    <= '0;
    end else begin
      if (g0)      last_gnt <= 1'b0;
      else if (g1) last_gnt <= 1'b1;
      if (idle && bus.req0 && bus.req1 && coll_q != 16'hFFFF)
        coll_q <= coll_q + 16'd1;
      rvalid_q <= {g1 & ~bus.we1, g0 & ~bus.we0};
      if (rvalid_q[0]) hold0 <= m_rdata;
      if (rvalid_q[1]) hold1 <= m_rdata;
    end
  end

  // Fresh data is shown straight from the RAM on the pulse cycle
  assign bus.rvalid0 = rvalid_q[0];
  assign bus.rvalid1 = rvalid_q[1];
  assign bus.rdata0  = rvalid_q[0] ? m_rdata : hold0;
  assign bus.rdata1  = rvalid_q[1] ? m_rdata : hold1;
  assign coll_cnt    = coll_q;

endmodule
